// File: rtl/axis_adc_acq_ctrl.sv
// ---------------------------------------------------------------------------
// axis_adc_acq_ctrl
//
// Triggered acquisition controller between the ADC sample stream and the
// DMA/packetizer. After an arm pulse it skips a holdoff of cfg_pre valid
// samples, waits for a level crossing or an external trigger, then forwards
// cfg_post samples (0 behaves as 1) as one AXI4-Stream packet ending in tlast.
//
// Ports
//   aclk, areset       clock, synchronous active-high reset
//   arm, abort         single-cycle control pulses (abort has priority)
//   cfg_pre            holdoff length in valid samples
//   cfg_post           packet length in samples
//   cfg_level          signed trigger threshold
//   cfg_slope          1 = rising crossing, 0 = falling crossing
//   cfg_src            0 = level trigger, 1 = external trigger
//   trg_ext            external trigger, looked at on valid samples only
//   s_axis_*           ADC sample stream (no tready)
//   m_axis_*           packet output through a 1-deep register
//   sts_state          current state encoding (see table below)
//   sts_overflow       sticky: a capture sample was dropped by backpressure
//   sts_trg_pos        valid samples since arm, including the trigger sample
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for arm
// HOLDOFF    | counting cfg_pre valid samples before detection is enabled
// WAIT_TRIG  | looking for the trigger condition on each valid sample
// CAPTURE    | forwarding samples until the packet length is reached
// DONE       | packet finished; pending output drains, input is ignored
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_adc_acq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [CNTR_WIDTH-1:0] cfg_pre,
    input  logic [CNTR_WIDTH-1:0] cfg_post,
    input  logic [DATA_WIDTH-1:0] cfg_level,
    input  logic                  cfg_slope,
    input  logic                  cfg_src,
    input  logic                  trg_ext,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [2:0]            sts_state,
    output logic                  sts_overflow,
    output logic [CNTR_WIDTH-1:0] sts_trg_pos
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] CNT_MAX  = '1;

    state_t state, state_nxt;

    logic [CNTR_WIDTH-1:0] hold_rem;
    logic [CNTR_WIDTH-1:0] len_rem;
    logic [CNTR_WIDTH-1:0] ts_cnt;
    logic [CNTR_WIDTH-1:0] ts_inc;
    logic [CNTR_WIDTH-1:0] trg_pos;
    logic [DATA_WIDTH-1:0] level_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  slope_q;
    logic                  src_q;
    logic                  prev_has;
    logic                  out_valid;
    logic                  out_last;
    logic                  overflow;

    logic arm_acc;
    logic running;
    logic take;
    logic cross_rise;
    logic cross_fall;
    logic trig_hit;
    logic cap_smp;
    logic cap_last;
    logic out_fire;
    logic out_load;

    assign arm_acc = arm && !abort && (state == ST_IDLE || state == ST_DONE);
    assign running = (state == ST_HOLDOFF) || (state == ST_WAIT_TRIG) || (state == ST_CAPTURE);
    assign take    = s_axis_tvalid && running;

    // prev_has blocks a false crossing against a stale prev from before arm
    assign cross_rise = prev_has && ($signed(prev_q) < $signed(level_q))
                        && ($signed(s_axis_tdata) >= $signed(level_q));
    assign cross_fall = prev_has && ($signed(prev_q) > $signed(level_q))
                        && ($signed(s_axis_tdata) <= $signed(level_q));
    assign trig_hit   = s_axis_tvalid && (src_q ? trg_ext : (slope_q ? cross_rise : cross_fall));

    // The trigger sample is the first captured sample
    assign cap_smp  = s_axis_tvalid && ((state == ST_WAIT_TRIG && trig_hit) || state == ST_CAPTURE);
    assign cap_last = (len_rem <= CNT_ONE);

    assign out_fire = out_valid && m_axis_tready;
    assign out_load = cap_smp && (!out_valid || m_axis_tready);

    assign ts_inc = (ts_cnt == CNT_MAX) ? ts_cnt : ts_cnt + CNT_ONE;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) state_nxt = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (hold_rem == CNT_ZERO) begin
                        state_nxt = ST_WAIT_TRIG;
                    end else if (s_axis_tvalid && hold_rem == CNT_ONE) begin
                        state_nxt = ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (cap_smp) state_nxt = cap_last ? ST_DONE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (cap_smp && cap_last) state_nxt = ST_DONE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            hold_rem  <= '0;
            len_rem   <= '0;
            ts_cnt    <= '0;
            trg_pos   <= '0;
            level_q   <= '0;
            prev_q    <= '0;
            slope_q   <= 1'b0;
            src_q     <= 1'b0;
            prev_has  <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (arm_acc) begin
                level_q  <= cfg_level;
                slope_q  <= cfg_slope;
                src_q    <= cfg_src;
                hold_rem <= cfg_pre;
                len_rem  <= (cfg_post == CNT_ZERO) ? CNT_ONE : cfg_post;
                ts_cnt   <= '0;
                trg_pos  <= '0;
                overflow <= 1'b0;
                prev_has <= 1'b0;
            end

            if (take) begin
                ts_cnt   <= ts_inc;
                prev_q   <= s_axis_tdata;
                prev_has <= 1'b1;
            end

            if (state == ST_HOLDOFF && s_axis_tvalid && hold_rem != CNT_ZERO) begin
                hold_rem <= hold_rem - CNT_ONE;
            end

            if (cap_smp) begin
                if (len_rem != CNT_ZERO) len_rem <= len_rem - CNT_ONE;
                if (state == ST_WAIT_TRIG) trg_pos <= ts_inc;
                if (!out_load) overflow <= 1'b1;
            end

            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= s_axis_tdata;
                out_last  <= cap_last;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;
    assign sts_state     = state;
    assign sts_overflow  = overflow;
    assign sts_trg_pos   = trg_pos;

endmodule

// File: tb/tb_axis_adc_acq_ctrl.sv
`timescale 1ns/1ps

module tb_axis_adc_acq_ctrl;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_pre = '0;
    logic [31:0] cfg_post = '0;
    logic [15:0] cfg_level = '0;
    logic        cfg_slope = 1'b0;
    logic        cfg_src = 1'b0;
    logic        trg_ext = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [15:0] s_axis_tdata = '0;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tvalid;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [2:0]  sts_state;
    logic        sts_overflow;
    logic [31:0] sts_trg_pos;

    axis_adc_acq_ctrl dut (
        .aclk          (aclk),
        .areset        (areset),
        .arm           (arm),
        .abort         (abort),
        .cfg_pre       (cfg_pre),
        .cfg_post      (cfg_post),
        .cfg_level     (cfg_level),
        .cfg_slope     (cfg_slope),
        .cfg_src       (cfg_src),
        .trg_ext       (trg_ext),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .sts_state     (sts_state),
        .sts_overflow  (sts_overflow),
        .sts_trg_pos   (sts_trg_pos)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: phase 0..4 = idle/holdoff/wait/capture/done, counting
    // samples upward since arm and packet samples upward since trigger.
    int          m_phase = 0;
    int unsigned m_nv = 0;
    int unsigned m_ncap = 0;
    int unsigned m_pre = 0;
    int unsigned m_len = 1;
    int          m_level = 0;
    bit          m_slope = 0;
    bit          m_src = 0;
    int          m_prev = 0;
    bit          m_have_prev = 0;
    int unsigned m_pos = 0;
    bit          m_ov = 0;
    bit          m_oval = 0;
    int          m_odata = 0;
    bit          m_olast = 0;

    logic [15:0] cap_data[$];
    logic        cap_last[$];

    task automatic model_offer(input int cur, input bit last, input bit acc, inout bit loaded);
        if (!m_oval || acc) begin
            m_oval  = 1;
            m_odata = cur;
            m_olast = last;
            loaded  = 1;
        end else begin
            m_ov = 1;
        end
    endtask

    task automatic model_step();
        bit acc;
        bit loaded;
        bit trig;
        int cur;
        acc    = m_oval && m_axis_tready;
        loaded = 0;
        cur    = int'($signed(s_axis_tdata));
        if (areset) begin
            m_phase = 0; m_nv = 0; m_ncap = 0; m_pre = 0; m_len = 1; m_level = 0;
            m_slope = 0; m_src = 0; m_prev = 0; m_have_prev = 0; m_pos = 0;
            m_ov = 0; m_oval = 0; m_odata = 0; m_olast = 0;
            return;
        end
        if (abort) begin
            m_phase = 0; m_oval = 0; m_odata = 0; m_olast = 0;
            return;
        end
        if (arm && (m_phase == 0 || m_phase == 4)) begin
            m_pre = cfg_pre;
            m_len = (cfg_post == 0) ? 1 : cfg_post;
            m_level = int'($signed(cfg_level));
            m_slope = cfg_slope;
            m_src = cfg_src;
            m_nv = 0; m_ncap = 0; m_pos = 0; m_ov = 0; m_have_prev = 0;
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (s_axis_tvalid) begin
                m_nv++;
                m_prev = cur;
                m_have_prev = 1;
            end
            if (m_pre == 0 || (s_axis_tvalid && m_nv == m_pre)) m_phase = 2;
        end else if (m_phase == 2 && s_axis_tvalid) begin
            m_nv++;
            if (m_src)
                trig = trg_ext;
            else if (m_slope)
                trig = m_have_prev && (m_prev < m_level) && (cur >= m_level);
            else
                trig = m_have_prev && (m_prev > m_level) && (cur <= m_level);
            m_prev = cur;
            m_have_prev = 1;
            if (trig) begin
                m_pos  = m_nv;
                m_ncap = 1;
                model_offer(cur, m_ncap == m_len, acc, loaded);
                m_phase = (m_ncap == m_len) ? 4 : 3;
            end
        end else if (m_phase == 3 && s_axis_tvalid) begin
            m_nv++;
            m_prev = cur;
            m_ncap++;
            model_offer(cur, m_ncap == m_len, acc, loaded);
            if (m_ncap == m_len) m_phase = 4;
        end
        if (!loaded && acc) m_oval = 0;
    endtask

    always @(posedge aclk) begin
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            cap_data.push_back(m_axis_tdata);
            cap_last.push_back(m_axis_tlast);
        end
        model_step();
        #1;
        check_val("state", 32'(sts_state), 32'(m_phase));
        check_val("tvalid", 32'(m_axis_tvalid), 32'(m_oval));
        if (m_oval) begin
            check_val("tdata", 32'(m_axis_tdata), 32'(m_odata[15:0]));
            check_val("tlast", 32'(m_axis_tlast), 32'(m_olast));
        end
        check_val("overflow", 32'(sts_overflow), 32'(m_ov));
        check_val("trg_pos", sts_trg_pos, m_pos);
    end

    task automatic drv(input logic v, input logic [15:0] d, input logic e);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        trg_ext       = e;
        @(negedge aclk);
    endtask

    task automatic do_arm(input int unsigned pre, input int unsigned post, input int level,
                          input logic slope, input logic src);
        cfg_pre   = pre;
        cfg_post  = post;
        cfg_level = level[15:0];
        cfg_slope = slope;
        cfg_src   = src;
        arm = 1'b1;
        drv(1'b0, 16'd0, 1'b0);
        arm = 1'b0;
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_last.delete();
    endtask

    initial begin
        int v;
        logic [15:0] d;
        @(negedge aclk);
        @(negedge aclk);
        check_val("rst_state", 32'(sts_state), 32'd0);
        check_val("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("rst_tdata", 32'(m_axis_tdata), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // 1: rising level trigger on a ramp
        clear_cap();
        m_axis_tready = 1'b1;
        do_arm(4, 8, 100, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) drv(1'b1, 16'(k * 20), 1'b0);
        drv(1'b0, 16'd0, 1'b0);
        drv(1'b0, 16'd0, 1'b0);
        check_val("t1_trg_pos", sts_trg_pos, 32'd6);
        check_val("t1_state", 32'(sts_state), 32'd4);
        check_val("t1_count", 32'(cap_data.size()), 32'd8);
        if (cap_data.size() == 8) begin
            check_val("t1_first", 32'(cap_data[0]), 32'd100);
            check_val("t1_last_data", 32'(cap_data[7]), 32'd240);
            check_val("t1_tlast", 32'(cap_last[7]), 32'd1);
            check_val("t1_no_early_tlast", 32'(cap_last[6]), 32'd0);
        end

        // 2: external trigger with falling-slope setting
        clear_cap();
        do_arm(3, 5, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) drv(1'b1, 16'(1000 + k * 7), k == 10);
        drv(1'b0, 16'd0, 1'b0);
        check_val("t2_trg_pos", sts_trg_pos, 32'd10);
        check_val("t2_count", 32'(cap_data.size()), 32'd5);
        if (cap_data.size() > 0) check_val("t2_first", 32'(cap_data[0]), 32'd1070);

        // 3: backpressure overflow, then drain
        clear_cap();
        m_axis_tready = 1'b0;
        do_arm(2, 4, 0, 1'b1, 1'b1);
        for (int k = 1; k <= 8; k++) drv(1'b1, 16'(k * 11), k == 3);
        check_val("t3_state", 32'(sts_state), 32'd4);
        check_val("t3_overflow", 32'(sts_overflow), 32'd1);
        check_val("t3_held_valid", 32'(m_axis_tvalid), 32'd1);
        check_val("t3_held_data", 32'(m_axis_tdata), 32'd33);
        check_val("t3_held_tlast", 32'(m_axis_tlast), 32'd0);
        m_axis_tready = 1'b1;
        drv(1'b0, 16'd0, 1'b0);
        drv(1'b0, 16'd0, 1'b0);
        check_val("t3_drained", 32'(cap_data.size()), 32'd1);
        check_val("t3_tvalid_low", 32'(m_axis_tvalid), 32'd0);

        // 4: abort during capture, arm+abort, arm ignored while waiting
        do_arm(1, 20, 0, 1'b1, 1'b1);
        drv(1'b1, 16'd10, 1'b0);
        drv(1'b1, 16'd11, 1'b1);
        drv(1'b1, 16'd12, 1'b0);
        drv(1'b1, 16'd13, 1'b0);
        abort = 1'b1;
        drv(1'b1, 16'd14, 1'b0);
        abort = 1'b0;
        check_val("t4_abort_state", 32'(sts_state), 32'd0);
        check_val("t4_abort_tvalid", 32'(m_axis_tvalid), 32'd0);
        arm = 1'b1;
        abort = 1'b1;
        drv(1'b0, 16'd0, 1'b0);
        arm = 1'b0;
        abort = 1'b0;
        check_val("t4_arm_abort", 32'(sts_state), 32'd0);
        do_arm(0, 3, 1000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drv(1'b1, 16'd0, 1'b0);
        check_val("t4_wait", 32'(sts_state), 32'd2);
        cfg_src = 1'b1;
        arm = 1'b1;
        drv(1'b1, 16'd0, 1'b1);
        arm = 1'b0;
        drv(1'b1, 16'd0, 1'b1);
        drv(1'b1, 16'd0, 1'b1);
        check_val("t4_arm_ignored", 32'(sts_state), 32'd2);
        abort = 1'b1;
        drv(1'b0, 16'd0, 1'b0);
        abort = 1'b0;

        // 5: zero holdoff and zero length, crossing on first two samples
        clear_cap();
        do_arm(0, 0, 0, 1'b1, 1'b0);
        drv(1'b1, 16'hFFFB, 1'b0);
        drv(1'b1, 16'd5, 1'b0);
        drv(1'b1, 16'd7, 1'b0);
        drv(1'b1, 16'd9, 1'b0);
        check_val("t5_trg_pos", sts_trg_pos, 32'd2);
        check_val("t5_count", 32'(cap_data.size()), 32'd1);
        if (cap_data.size() == 1) begin
            check_val("t5_data", 32'(cap_data[0]), 32'd5);
            check_val("t5_tlast", 32'(cap_last[0]), 32'd1);
        end

        // 6: gapped input, one valid sample every third cycle
        clear_cap();
        do_arm(3, 4, 0, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            drv(1'b1, 16'(k * 11), k == 5);
            drv(1'b0, 16'd0, 1'b0);
            drv(1'b0, 16'd0, 1'b0);
        end
        check_val("t6_trg_pos", sts_trg_pos, 32'd5);
        check_val("t6_count", 32'(cap_data.size()), 32'd4);
        if (cap_data.size() == 4) begin
            check_val("t6_first", 32'(cap_data[0]), 32'd55);
            check_val("t6_last_data", 32'(cap_data[3]), 32'd88);
            check_val("t6_tlast", 32'(cap_last[3]), 32'd1);
        end

        // 7: reset mid-packet
        do_arm(0, 10, 0, 1'b1, 1'b1);
        drv(1'b1, 16'd1, 1'b1);
        drv(1'b1, 16'd2, 1'b1);
        drv(1'b1, 16'd3, 1'b0);
        areset = 1'b1;
        drv(1'b1, 16'd4, 1'b0);
        areset = 1'b0;
        check_val("t7_state", 32'(sts_state), 32'd0);
        check_val("t7_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("t7_tlast", 32'(m_axis_tlast), 32'd0);

        // Randomized traffic; config toggles every cycle to exercise latching
        for (int n = 0; n < 3000; n++) begin
            cfg_pre   = $urandom_range(0, 5);
            cfg_post  = $urandom_range(0, 6);
            v         = int'($urandom_range(0, 80)) - 40;
            cfg_level = v[15:0];
            cfg_slope = 1'($urandom_range(0, 1));
            cfg_src   = ($urandom_range(0, 3) == 0);
            arm       = ($urandom_range(0, 19) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            areset    = ($urandom_range(0, 499) == 0);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            v = int'($urandom_range(0, 100)) - 50;
            d = v[15:0];
            drv($urandom_range(0, 2) != 0, d, $urandom_range(0, 7) == 0);
        end
        arm = 1'b0;
        abort = 1'b0;
        areset = 1'b0;
        m_axis_tready = 1'b1;
        drv(1'b0, 16'd0, 1'b0);
        drv(1'b0, 16'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_adc_acq_ctrl.md
# axis_adc_acq_ctrl

Triggered acquisition controller between the ADC sample stream and the DMA/packetizer path. After an arm pulse it waits a programmable pre-trigger holdoff, detects a level-crossing or external trigger, then forwards exactly a programmed number of samples as one AXI4-Stream packet with `tlast`. It runs in the ADC clock domain and reports state, overflow and trigger timestamp for the register bank.

## Interface

**Parameters**
- DATA_WIDTH, 16, sample width; samples are two's complement.
- CNTR_WIDTH, 32, width of the holdoff, length and timestamp counters.

**Ports**
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle start pulse.
- abort  in  1  single-cycle abort pulse.
- cfg_pre  in  CNTR_WIDTH  holdoff, in valid samples, before trigger detection is enabled.
- cfg_post  in  CNTR_WIDTH  packet length in samples; 0 is treated as 1.
- cfg_level  in  DATA_WIDTH  signed trigger threshold.
- cfg_slope  in  1  1 = rising crossing, 0 = falling crossing.
- cfg_src  in  1  0 = level trigger, 1 = external trigger.
- trg_ext  in  1  external trigger, level-sensitive, sampled on valid samples only.
- s_axis_tvalid  in  1  sample strobe from the ADC; there is no tready.
- s_axis_tdata  in  DATA_WIDTH  signed sample.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tlast  out  1  last sample of the packet.
- sts_state  out  3  IDLE=0, HOLDOFF=1, WAIT_TRIG=2, CAPTURE=3, DONE=4.
- sts_overflow  out  1  sticky flag: a sample was dropped by backpressure.
- sts_trg_pos  out  CNTR_WIDTH  number of valid samples since arm, up to and including the trigger sample.

## Operation

- **Config latching:** all `cfg_*` inputs are latched on an accepted arm. Later changes have no effect until the next arm.
- **Accepted arm:** arm is accepted only in IDLE or DONE. An accepted arm clears `sts_overflow`, `sts_trg_pos` and the counters, then enters HOLDOFF. Arm in any other state is ignored.
- **abort:** returns to IDLE from any state and clears the output register (`m_axis_tvalid`=0). abort wins over a simultaneous arm.
- **Timestamp counter:** counts every valid sample while in HOLDOFF, WAIT_TRIG or CAPTURE.
- **HOLDOFF:** counts valid samples. Moves to WAIT_TRIG on the cycle the count reaches `cfg_pre`. If `cfg_pre`=0, it moves to WAIT_TRIG on the cycle after arm.
- **WAIT_TRIG, level source:** keeps the previous valid sample, updated in every state except IDLE and DONE.
  - Rising (`cfg_slope`=1): trigger when prev < `cfg_level` and cur >= `cfg_level`, signed compare.
  - Falling (`cfg_slope`=0): trigger when prev > `cfg_level` and cur <= `cfg_level`.
  - The first valid sample in WAIT_TRIG can trigger only if prev holds a sample from HOLDOFF. With `cfg_pre`=0, the first sample only loads prev.
- **WAIT_TRIG, external source:** trigger is `trg_ext`=1 on a valid sample.
- **On trigger:** `sts_trg_pos` is loaded with the timestamp including the trigger sample. The trigger sample is the first output sample, and the state moves to CAPTURE.
- **CAPTURE:** every valid sample, including the trigger sample, decrements the remaining count, whether or not it is forwarded.
  - Output is a 1-deep register. A sample loads it if the register is empty or is being accepted this cycle (`m_axis_tvalid`&`m_axis_tready`).
  - Otherwise the sample is dropped and `sts_overflow` is set.
- **tlast and DONE:** tlast is attached to the sample whose count reaches `cfg_post`, and the state moves to DONE on that cycle. If that sample is dropped, no tlast is emitted; `sts_overflow` tells software the packet is bad.
- **DONE:** the pending output word drains normally. Input samples are ignored.
- **Counters:** saturate at all-ones and never wrap.

## Timing

- **Reset values:** all outputs 0; `sts_state`=IDLE.
- **Latency:** 1 cycle from an accepted `s_axis` sample to `m_axis_tvalid`/tdata/tlast.
- **State changes:** `sts_state` updates the cycle after the causing event.
- **Output handshake:** tdata and tlast are stable while tvalid=1 and tready=0. tvalid is never withdrawn without a handshake, except by abort or reset.
- **Back-to-back samples:** with tready=1 sustained, one sample per clock passes with no loss.
- **Reset mid-packet:** tvalid drops on the next edge, no tlast is emitted, and the block returns to IDLE.

## Test plan

1. **Level trigger, rising slope.** Setup: `cfg_pre`=4, `cfg_post`=8, `cfg_level`=100, rising, tready=1, ramp input 0,20,40,… every cycle. Required:
   - Trigger on sample 100.
   - 8 outputs: 100..240.
   - tlast on 240.
   - `sts_trg_pos`=6.
   - DONE.
2. **External trigger, falling setting.** Setup: `cfg_src`=1, `trg_ext` pulsed on the 10th valid sample. Required:
   - That sample is the first output.
   - The falling-slope setting has no effect.
   - `sts_trg_pos`=10.
3. **Backpressure overflow.** Setup: `cfg_post`=4, tready=0 throughout capture. Required:
   - Exactly 1 word is held (the trigger sample).
   - `sts_overflow`=1.
   - DONE after 4 valid samples.
   - The held word drains when tready rises.
4. **abort and arm handling.** Required:
   - abort during CAPTURE → IDLE and tvalid=0 next cycle.
   - arm and abort in the same cycle → IDLE.
   - arm during WAIT_TRIG → ignored.
5. **Edge cases.** Setup: `cfg_post`=0, `cfg_pre`=0. Required:
   - A one-sample packet with tlast.
   - A crossing between the first two samples after arm triggers on the second sample.
6. **Gapped input.** Setup: s_axis_tvalid asserted every third cycle. Required:
   - Holdoff and length count valid samples only.
   - Output spacing matches the input spacing.
